// File: rtl/joypad_pkg.sv
// Shared types and constants for the joypad polling controller: FSM states,
// button bit positions and default timing.
package joypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_BIT_HI  = 3'd2,
    ST_BIT_LO  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int PAD_W = 8;

  localparam int DEF_STROBE_CYCLES = 12;
  localparam int DEF_BIT_CYCLES    = 24;
  localparam int DEF_PULSE_CYCLES  = 6;
  localparam int DEF_NUM_BITS      = 8;
  localparam int DEF_MAX_RETRY     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/joypad_poll_ctrl_if.sv
// System/connector-side signal bundle of the joypad polling controller.
interface joypad_poll_ctrl_if;
  import joypad_pkg::*;

  logic             start;
  logic [1:0]       port_mask;
  logic             p1_d0;
  logic             p2_d0;
  logic             out0;
  logic             noe1;
  logic             noe2;
  logic [PAD_W-1:0] pad1;
  logic [PAD_W-1:0] pad2;
  logic             busy;
  logic             done;
  logic             valid;
  logic             mismatch;

  modport slave (
    input  start, port_mask, p1_d0, p2_d0,
    output out0, noe1, noe2, pad1, pad2, busy, done, valid, mismatch
  );

  modport master (
    output start, port_mask, p1_d0, p2_d0,
    input  out0, noe1, noe2, pad1, pad2, busy, done, valid, mismatch
  );

endinterface

// File: rtl/joypad_shift_capture.sv
// Per-port shadow shift register (pressed=1, bit0 first) plus, with
// POLL_DOUBLE_READ_EN, a copy of the first pass for comparison.
module joypad_shift_capture
  import joypad_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_shift,
  input  logic             i_d0,
`ifdef POLL_DOUBLE_READ_EN
  input  logic             i_copy,
  output logic             o_match_next,
`endif
  output logic [PAD_W-1:0] o_shadow_next
);

  logic [PAD_W-1:0] r_shadow;
  logic [PAD_W-1:0] w_shadow_next;

  // Connector data is active-low; the shadow stores 1=pressed.
  assign w_shadow_next = i_shift ? {~i_d0, r_shadow[PAD_W-1:1]} : r_shadow;
  assign o_shadow_next = w_shadow_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_shadow <= '0;
    else          r_shadow <= w_shadow_next;
  end

`ifdef POLL_DOUBLE_READ_EN
  logic [PAD_W-1:0] r_copy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_copy <= '0;
    else if (i_copy) r_copy <= w_shadow_next;
  end

  // Compared against the value the shadow takes at this edge, so the final
  // bit of pass 2 is included without an extra cycle.
  assign o_match_next = (w_shadow_next == r_copy);
`endif

endmodule

// File: rtl/joypad_poll_ctrl.sv
// Autonomous two-port joypad poller: strobe, clock NUM_BITS bits, publish pads.
// Optional POLL_DOUBLE_READ_EN: read each attempt twice and retry on mismatch.
module joypad_poll_ctrl
  import joypad_pkg::*;
#(
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int BIT_CYCLES    = DEF_BIT_CYCLES,
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int NUM_BITS      = DEF_NUM_BITS
`ifdef POLL_DOUBLE_READ_EN
  ,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
`endif
)
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  joypad_poll_ctrl_if.slave  io_bus
);

  localparam int CNT_W = $clog2(max_int(STROBE_CYCLES, BIT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HI_LAST     = CNT_W'(BIT_CYCLES - PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST    = 3'(NUM_BITS - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit, w_bit_next;
  logic [1:0]       r_mask, w_mask_next;
  logic             w_shift;
  logic [PAD_W-1:0] w_sh1_next, w_sh2_next;

  logic             r_out0, r_noe1, r_noe2, r_busy, r_done, r_valid;
  logic [PAD_W-1:0] r_pad1, r_pad2;

  assign w_shift = (r_state == ST_BIT_LO) && (r_cnt == PULSE_LAST);

`ifdef POLL_DOUBLE_READ_EN
  localparam int ATT_W = $clog2(max_int(MAX_RETRY, 1) + 1);
  localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(MAX_RETRY);

  logic             r_pass, w_pass_next;
  logic [ATT_W-1:0] r_attempt, w_attempt_next;
  logic             w_copy, w_match1, w_match2, w_match;
  logic             r_mismatch;

  assign w_copy  = w_shift && (r_bit == BIT_LAST) && !r_pass;
  // Disabled ports never cause a retry.
  assign w_match = (!r_mask[0] || w_match1) && (!r_mask[1] || w_match2);
`endif

  joypad_shift_capture u_cap1 (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_shift       (w_shift),
    .i_d0          (io_bus.p1_d0),
`ifdef POLL_DOUBLE_READ_EN
    .i_copy        (w_copy),
    .o_match_next  (w_match1),
`endif
    .o_shadow_next (w_sh1_next)
  );

  joypad_shift_capture u_cap2 (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_shift       (w_shift),
    .i_d0          (io_bus.p2_d0),
`ifdef POLL_DOUBLE_READ_EN
    .i_copy        (w_copy),
    .o_match_next  (w_match2),
`endif
    .o_shadow_next (w_sh2_next)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_mask_next  = r_mask;
`ifdef POLL_DOUBLE_READ_EN
    w_pass_next    = r_pass;
    w_attempt_next = r_attempt;
`endif
    case (r_state)
      ST_IDLE, ST_FINISH: begin
        w_state_next = ST_IDLE;
        if (io_bus.start) begin
          w_state_next = ST_STROBE;
          w_cnt_next   = '0;
          w_mask_next  = io_bus.port_mask;
`ifdef POLL_DOUBLE_READ_EN
          w_pass_next    = 1'b0;
          w_attempt_next = '0;
`endif
        end
      end
      ST_STROBE: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == STROBE_LAST) begin
          w_state_next = ST_BIT_HI;
          w_cnt_next   = '0;
          w_bit_next   = '0;
        end
      end
      ST_BIT_HI: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == HI_LAST) begin
          w_state_next = ST_BIT_LO;
          w_cnt_next   = '0;
        end
      end
      ST_BIT_LO: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == PULSE_LAST) begin
          w_cnt_next = '0;
          if (r_bit == BIT_LAST) begin
`ifdef POLL_DOUBLE_READ_EN
            if (!r_pass) begin
              w_state_next = ST_STROBE;
              w_pass_next  = 1'b1;
            end else if (w_match) begin
              w_state_next = ST_FINISH;
            end else begin
              w_state_next = ST_COMPARE;
            end
`else
            w_state_next = ST_FINISH;
`endif
          end else begin
            w_state_next = ST_BIT_HI;
            w_bit_next   = r_bit + 3'd1;
          end
        end
      end
`ifdef POLL_DOUBLE_READ_EN
      ST_COMPARE: begin
        if (r_attempt == ATT_LAST) begin
          w_state_next = ST_FINISH;
        end else begin
          w_state_next   = ST_STROBE;
          w_cnt_next     = '0;
          w_pass_next    = 1'b0;
          w_attempt_next = r_attempt + ATT_W'(1);
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_mask  <= w_mask_next;
    end
  end

`ifdef POLL_DOUBLE_READ_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass     <= 1'b0;
      r_attempt  <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_pass     <= w_pass_next;
      r_attempt  <= w_attempt_next;
      r_mismatch <= (r_state == ST_COMPARE) && (w_state_next == ST_FINISH);
    end
  end

  assign io_bus.mismatch = r_mismatch;
`else
  assign io_bus.mismatch = 1'b0;
`endif

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out0  <= 1'b0;
      r_noe1  <= 1'b1;
      r_noe2  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_pad1  <= '0;
      r_pad2  <= '0;
    end else begin
      r_out0 <= (w_state_next == ST_STROBE);
      r_noe1 <= !((w_state_next == ST_BIT_LO) && r_mask[0]);
      r_noe2 <= !((w_state_next == ST_BIT_LO) && r_mask[1]);
      r_busy <= (w_state_next != ST_IDLE) && (w_state_next != ST_FINISH);
      r_done <= (w_state_next == ST_FINISH);
      if (w_state_next == ST_FINISH) begin
        r_valid <= 1'b1;
        if (r_mask[0]) r_pad1 <= w_sh1_next;
        if (r_mask[1]) r_pad2 <= w_sh2_next;
      end
    end
  end

  assign io_bus.out0  = r_out0;
  assign io_bus.noe1  = r_noe1;
  assign io_bus.noe2  = r_noe2;
  assign io_bus.busy  = r_busy;
  assign io_bus.done  = r_done;
  assign io_bus.valid = r_valid;
  assign io_bus.pad1  = r_pad1;
  assign io_bus.pad2  = r_pad2;

endmodule

// File: tb/tb_joypad_poll_ctrl.sv
// Self-checking bench for joypad_poll_ctrl: 4021-style pad models on both
// ports, directed plus randomized polls against a high-level expectation model.
module tb_joypad_poll_ctrl;
  import joypad_pkg::*;

  localparam int T_STROBE = 12;
  localparam int T_BIT    = 24;
  localparam int T_PULSE  = 6;
  localparam int N_BITS   = 8;
  localparam int LAT1     = T_STROBE + N_BITS * T_BIT + 1;
`ifdef POLL_DOUBLE_READ_EN
  localparam int PASSES = 2;
  localparam int LAT    = 2 * LAT1 - 1;
`else
  localparam int PASSES = 1;
  localparam int LAT    = LAT1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  joypad_poll_ctrl_if bus ();

  joypad_poll_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] btn1 = '0, btn2 = '0;
  logic [7:0] exp_pad1 = '0, exp_pad2 = '0;
  bit         tgl = 1'b0;

  int cyc = 0, n_strobes = 0, done_cnt = 0;
  int pulses1 = 0, pulses2 = 0, badlen = 0, lo1 = 0, lo2 = 0;
  int idx1 = 8, idx2 = 8;
  logic [7:0] lat1 = '0, lat2 = '0;
  logic prev_out0 = 1'b0, prev_noe1 = 1'b1, prev_noe2 = 1'b1;

  // Pad devices: latch buttons on strobe, shift on rising nOE, D0 low = pressed.
  assign bus.p1_d0 = (idx1 < 8) ? ~lat1[idx1[2:0]] : 1'b1;
  assign bus.p2_d0 = (idx2 < 8) ? ~lat2[idx2[2:0]] : 1'b1;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_out0 <= bus.out0;
    prev_noe1 <= bus.noe1;
    prev_noe2 <= bus.noe2;
    if (bus.out0 && !prev_out0) begin
      lat1      <= btn1 ^ ((tgl && n_strobes[0]) ? 8'h08 : 8'h00);
      lat2      <= btn2;
      idx1      <= 0;
      idx2      <= 0;
      n_strobes <= n_strobes + 1;
    end else begin
      if (bus.noe1 && !prev_noe1) idx1 <= idx1 + 1;
      if (bus.noe2 && !prev_noe2) idx2 <= idx2 + 1;
    end
    if (!bus.noe1) lo1 <= lo1 + 1;
    else if (lo1 != 0) begin
      pulses1 <= pulses1 + 1;
      if (lo1 != T_PULSE) badlen <= badlen + 1;
      lo1 <= 0;
    end
    if (!bus.noe2) lo2 <= lo2 + 1;
    else if (lo2 != 0) begin
      pulses2 <= pulses2 + 1;
      if (lo2 != T_PULSE) badlen <= badlen + 1;
      lo2 <= 0;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [1:0] mask, output int t0);
    @(negedge clk);
    bus.port_mask = mask;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic poll_and_check(input string tag, input logic [1:0] mask);
    int t0, lat, p1, p2, bl;
    p1 = pulses1; p2 = pulses2; bl = badlen;
    accept(mask, t0);
    wait_done(t0, LAT + 100, lat);
    if (mask[0]) exp_pad1 = btn1;
    if (mask[1]) exp_pad2 = btn2;
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_pad1"}, bus.pad1, exp_pad1);
    check({tag, "_pad2"}, bus.pad2, exp_pad2);
    check({tag, "_valid"}, bus.valid, 1);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_mismatch"}, bus.mismatch, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_noe1_pulses"}, pulses1 - p1, mask[0] ? N_BITS * PASSES : 0);
    check({tag, "_noe2_pulses"}, pulses2 - p2, mask[1] ? N_BITS * PASSES : 0);
    check({tag, "_pulse_width"}, badlen - bl, 0);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, d0, base, n;
    int times[3];

    bus.start     = 1'b0;
    bus.port_mask = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out0", bus.out0, 0);
    check("rst_noe1", bus.noe1, 1);
    check("rst_noe2", bus.noe2, 1);
    check("rst_pad1", bus.pad1, 0);
    check("rst_pad2", bus.pad2, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_mismatch", bus.mismatch, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A + RIGHT on port 1, nothing on port 2
    btn1 = 8'h81; btn2 = 8'h00;
    poll_and_check("ar", 2'b11);

    // Port 2 masked off while its pad shows everything pressed
    btn1 = 8'($urandom); btn2 = 8'hFF;
    poll_and_check("mask01", 2'b01);

    // Randomized polls, random masks (including 00)
    for (int k = 0; k < 6; k++) begin
      btn1 = 8'($urandom); btn2 = 8'($urandom);
      poll_and_check("rnd", 2'($urandom_range(0, 3)));
    end

    // START held continuously: back-to-back polls
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    @(negedge clk);
    bus.port_mask = 2'b11;
    bus.start     = 1'b1;
    n = 0;
    for (int i = 0; i < 3 * LAT + 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        times[n] = cyc;
        n++;
        if (n == 3) break;
      end
    end
    bus.start = 1'b0;
    exp_pad1 = btn1; exp_pad2 = btn2;
    check("b2b_done_count", n, 3);
    check("b2b_gap1", times[1] - times[0], LAT);
    check("b2b_gap2", times[2] - times[1], LAT);
    check("b2b_pad1", bus.pad1, exp_pad1);
    check("b2b_pad2", bus.pad2, exp_pad2);
    repeat (2) @(negedge clk);
    check("b2b_idle", bus.busy, 0);

    // START pulsed while busy is ignored
    btn1 = 8'hA5; btn2 = 8'h3C;
    accept(2'b11, t0);
    repeat (48) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(t0, LAT + 100, lat);
    exp_pad1 = btn1; exp_pad2 = btn2;
    check("busy_start_latency", lat, LAT);
    check("busy_start_pad1", bus.pad1, exp_pad1);
    @(negedge clk);
    d0 = done_cnt;
    repeat (LAT + 20) @(negedge clk);
    check("busy_start_single_done", done_cnt - d0, 0);

    // Reset mid-poll
    d0 = done_cnt;
    accept(2'b11, t0);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out0", bus.out0, 0);
    check("midrst_noe1", bus.noe1, 1);
    check("midrst_noe2", bus.noe2, 1);
    check("midrst_pad1", bus.pad1, 0);
    check("midrst_pad2", bus.pad2, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_pad1 = '0; exp_pad2 = '0;
    repeat (LAT + 20) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_valid", bus.valid, 0);
    check("midrst_pad1_held", bus.pad1, 0);

    // A clean poll after reset
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    poll_and_check("post_rst", 2'b11);

`ifdef POLL_DOUBLE_READ_EN
    // Bit 3 of port 1 toggles between passes on every attempt
    tgl  = 1'b1;
    btn1 = 8'($urandom); btn2 = 8'($urandom);
    base = n_strobes;
    accept(2'b11, t0);
    wait_done(t0, 4 * LAT, lat);
    exp_pad1 = btn1 ^ (((base + 1) % 2 == 1) ? 8'h08 : 8'h00);
    exp_pad2 = btn2;
    check("dbl_done_seen", (lat > 0) ? 1 : 0, 1);
    check("dbl_mismatch", bus.mismatch, 1);
    check("dbl_pad1", bus.pad1, exp_pad1);
    check("dbl_pad2", bus.pad2, exp_pad2);
    @(negedge clk);
    check("dbl_mismatch_pulse", bus.mismatch, 0);
    check("dbl_strobes", n_strobes - base, 2 * (DEF_MAX_RETRY + 1));
    tgl = 1'b0;
    btn1 = 8'($urandom);
    poll_and_check("dbl_stable", 2'b11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
